hazard_ctrl_unit: RTL and testbench
===================================

// Module: hazard_ctrl_unit
// PURPOSE
// - Parametrised pipeline hazard controller for the 5-stage MIPS core. Generates PC/latch enables and flushes,
//   a one-bubble load-use interlock, and per-read-port forwarding selects.
// - Sequential D-cache wait FSM that captures an early ihit, plus a wait watchdog.
// - Sits beside the datapath; consumes stage-latch fields and cache hits.
// PARAMETERS
// - RADDR_W   5    register address width
// - NUM_SRC   2    ID/EX read ports needing forwarding (rs, rt, ...)
// - WDOG_W    8    watchdog counter width; timeout at 2**WDOG_W-1 wait cycles
// - CNT_W     32   perf counter width (HAZARD_PERF_EN only)
// PORTS
// - CLK           in   1                  clock, rising edge
// - nRST          in   1                  reset, synchronous, active-low
// - ihit          in   1                  I-cache hit this cycle
// - dhit          in   1                  D-cache hit this cycle
// - exmem_memop   in   1                  EX/MEM holds LW or SW
// - branch_flush  in   1                  taken branch resolved
// - jump_flush    in   1                  jump resolved
// - idex_memrd    in   1                  ID/EX holds LW
// - idex_wsel     in   RADDR_W            ID/EX destination register
// - ifid_rsel     in   NUM_SRC*RADDR_W    IF/ID source registers, port i at [i*RADDR_W +: RADDR_W]
// - idex_rsel     in   NUM_SRC*RADDR_W    ID/EX source registers, same packing
// - exmem_regwr   in   1                  EX/MEM writes regfile
// - exmem_wsel    in   RADDR_W            EX/MEM destination register
// - memwb_regwr   in   1                  MEM/WB writes regfile
// - memwb_wsel    in   RADDR_W            MEM/WB destination register
// - pc_wen, ifid_en, idex_en, exmem_en, memwb_en   out  1   stage enables
// - ifid_flush, idex_flush, exmem_flush            out  1   stage flushes
// - fwd_sel       out  2*NUM_SRC          per port: 10 = EX/MEM, 01 = MEM/WB, 00 = regfile
// - wdog_err      out  1                  sticky: D-cache wait timed out
// BEHAVIOUR
// - Reset (nRST low at CLK edge): state = RUN, ihit_q = 0, wdog = 0, wdog_err = 0.
//   While nRST is low, all enables and flushes = 0 and fwd_sel = 0.
// - FSM states RUN and DWAIT.
//   - RUN -> DWAIT when exmem_memop & !dhit.
//   - DWAIT -> RUN on the cycle dhit = 1.
// - ihit_q: set on ihit while in DWAIT or on RUN->DWAIT entry; cleared on DWAIT->RUN.
//   ihit_eff = ihit | ihit_q.
// - memstall = exmem_memop & !dhit (combinational, either state).
// - go = ihit_eff & !memstall.
// - In RUN or DWAIT: memwb_en = dhit | go; exmem_en = dhit | go; exmem_flush = dhit & !go.
// - load_use = idex_memrd & idex_wsel != 0 & (idex_wsel == any ifid_rsel port).
// - pc_wen = ifid_en = go & !load_use.
// - idex_en = go; idex_flush = go & (load_use | branch_flush | jump_flush).
// - ifid_flush = go & (branch_flush | jump_flush). Flush beats load_use for IF/ID: pc_wen = go when flushing.
// - Flush inputs persist while their stage is held, so flushes apply only when the pipeline advances.
// - fwd_sel[i]:
//   - 10 if exmem_regwr & exmem_wsel != 0 & exmem_wsel == idex_rsel[i];
//   - else 01 if the same condition holds for memwb;
//   - else 00. Register $0 is never forwarded.
// - Watchdog: wdog increments each DWAIT cycle and clears to 0 in RUN. At all-ones, wdog_err = 1 until reset.
//   The FSM is unaffected by the timeout.
// - Reset mid-DWAIT: back to RUN next edge; pending ihit_q discarded.
// CONFIGURATION
// - HAZARD_PERF_EN defined: adds outputs stall_cycles, lu_bubbles, flush_count (each CNT_W).
//   - stall_cycles +1 per cycle with !go.
//   - lu_bubbles +1 per go & load_use.
//   - flush_count +1 per ifid_flush.
//   - All zeroed on reset; saturate at all-ones.
// - Undefined: ports and counters absent; all other behaviour identical.
// TESTING
// - Reset with nRST = 0 for 2 cycles -> all enables 0, fwd_sel = 0, wdog_err = 0. Release with ihit = 1 -> pc_wen = 1.
// - LW in EX/MEM, dhit low 3 cycles, ihit pulse in 1st cycle ->
//   - pc_wen = 0 for 3 cycles, state DWAIT;
//   - dhit cycle: go = 1 with no new ihit, exmem_en = memwb_en = 1, ihit_q cleared.
// - idex_memrd = 1, idex_wsel = 8, ifid_rsel port1 = 8, ihit = 1 ->
//   pc_wen = ifid_en = 0, idex_flush = 1 for one cycle. With idex_wsel = 0 -> no stall.
// - exmem_wsel = memwb_wsel = 9 (both regwr), idex_rsel port0 = 9 -> fwd_sel[1:0] = 10;
//   exmem_regwr = 0 -> 01; wsel = 0 -> 00.
// - branch_flush = 1 with memstall -> no flush until dhit. On go: ifid_flush = idex_flush = 1,
//   also with a concurrent load_use (pc_wen = 1).
// - Hold DWAIT 255 cycles (WDOG_W = 8) -> wdog_err = 1. Stays 1 after dhit until nRST.
//   Under HAZARD_PERF_EN: stall_cycles = 255.

Source files
------------

// File: rtl/hazard_ctrl_unit.sv
// Hazard controller for the 5-stage MIPS core: stage enables/flushes, load-use interlock, forwarding, D-cache wait FSM.
// Optional HAZARD_PERF_EN adds saturating stall/bubble/flush counters.
module hazard_ctrl_unit #(
  parameter int RADDR_W = 5,
  parameter int NUM_SRC = 2,
  parameter int WDOG_W  = 8,
  parameter int CNT_W   = 32
) (
  input  logic                       CLK,
  input  logic                       nRST,
  input  logic                       ihit,
  input  logic                       dhit,
  input  logic                       exmem_memop,
  input  logic                       branch_flush,
  input  logic                       jump_flush,
  input  logic                       idex_memrd,
  input  logic [RADDR_W-1:0]         idex_wsel,
  input  logic [NUM_SRC*RADDR_W-1:0] ifid_rsel,
  input  logic [NUM_SRC*RADDR_W-1:0] idex_rsel,
  input  logic                       exmem_regwr,
  input  logic [RADDR_W-1:0]         exmem_wsel,
  input  logic                       memwb_regwr,
  input  logic [RADDR_W-1:0]         memwb_wsel,
  output logic                       pc_wen,
  output logic                       ifid_en,
  output logic                       idex_en,
  output logic                       exmem_en,
  output logic                       memwb_en,
  output logic                       ifid_flush,
  output logic                       idex_flush,
  output logic                       exmem_flush,
  output logic [2*NUM_SRC-1:0]       fwd_sel,
  output logic                       wdog_err
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0]           stall_cycles,
  output logic [CNT_W-1:0]           lu_bubbles,
  output logic [CNT_W-1:0]           flush_count
`endif
);

  typedef enum logic {RUN = 1'b0, DWAIT = 1'b1} state_t;

  localparam logic [WDOG_W-1:0] WDOG_MAX = '1;

  state_t             state, state_n;
  logic               ihit_q, ihit_q_n;
  logic [WDOG_W-1:0]  wdog;
  logic               ihit_eff, memstall, go, load_use, any_flush;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state  <= RUN;
      ihit_q <= 1'b0;
    end else begin
      state  <= state_n;
      ihit_q <= ihit_q_n;
    end
  end

  // ihit_q remembers an instruction fetch that completed while the D-cache was stalling.
  always_comb begin
    state_n  = state;
    ihit_q_n = ihit_q;
    case (state)
      RUN: begin
        if (memstall) begin
          state_n  = DWAIT;
          ihit_q_n = ihit;
        end else begin
          ihit_q_n = 1'b0;
        end
      end
      DWAIT: begin
        if (dhit) begin
          state_n  = RUN;
          ihit_q_n = 1'b0;
        end else begin
          ihit_q_n = ihit_q | ihit;
        end
      end
      default: begin
        state_n  = RUN;
        ihit_q_n = 1'b0;
      end
    endcase
  end

  always_comb begin
    load_use = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (idex_memrd && idex_wsel != '0 && idex_wsel == ifid_rsel[i*RADDR_W +: RADDR_W])
        load_use = 1'b1;
    end
  end

  assign ihit_eff  = ihit | ihit_q;
  assign memstall  = exmem_memop & ~dhit;
  assign go        = ihit_eff & ~memstall;
  assign any_flush = branch_flush | jump_flush;

  // A pending flush discards IF/ID anyway, so the load-use hold is pointless then.
  always_comb begin
    pc_wen      = 1'b0;
    ifid_en     = 1'b0;
    idex_en     = 1'b0;
    exmem_en    = 1'b0;
    memwb_en    = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    if (nRST) begin
      pc_wen      = go & (~load_use | any_flush);
      ifid_en     = go & (~load_use | any_flush);
      idex_en     = go;
      exmem_en    = dhit | go;
      memwb_en    = dhit | go;
      ifid_flush  = go & any_flush;
      idex_flush  = go & (load_use | any_flush);
      exmem_flush = dhit & ~go;
    end
  end

  always_comb begin
    fwd_sel = '0;
    if (nRST) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (exmem_regwr && exmem_wsel != '0 && exmem_wsel == idex_rsel[i*RADDR_W +: RADDR_W])
          fwd_sel[2*i +: 2] = 2'b10;
        else if (memwb_regwr && memwb_wsel != '0 && memwb_wsel == idex_rsel[i*RADDR_W +: RADDR_W])
          fwd_sel[2*i +: 2] = 2'b01;
      end
    end
  end

  // The error fires on the edge where wdog reaches all-ones; the count then holds there.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      wdog     <= '0;
      wdog_err <= 1'b0;
    end else if (state == DWAIT) begin
      if (wdog != WDOG_MAX) wdog <= wdog + 1'b1;
      if (wdog == WDOG_MAX - 1'b1) wdog_err <= 1'b1;
    end else begin
      wdog <= '0;
    end
  end

`ifdef HAZARD_PERF_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      stall_cycles <= '0;
      lu_bubbles   <= '0;
      flush_count  <= '0;
    end else begin
      if (!go && stall_cycles != CNT_MAX) stall_cycles <= stall_cycles + 1'b1;
      if (go && load_use && lu_bubbles != CNT_MAX) lu_bubbles <= lu_bubbles + 1'b1;
      if (ifid_flush && flush_count != CNT_MAX) flush_count <= flush_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit (default build, WDOG_W = 8).
module tb_hazard_ctrl_unit;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        ihit, dhit, exmem_memop, branch_flush, jump_flush, idex_memrd;
  logic [4:0]  idex_wsel, exmem_wsel, memwb_wsel;
  logic [9:0]  ifid_rsel, idex_rsel;
  logic        exmem_regwr, memwb_regwr;
  logic        pc_wen, ifid_en, idex_en, exmem_en, memwb_en;
  logic        ifid_flush, idex_flush, exmem_flush;
  logic [3:0]  fwd_sel;
  logic        wdog_err;

  int errors = 0;
  int checks = 0;

  hazard_ctrl_unit #(.RADDR_W(5), .NUM_SRC(2), .WDOG_W(8), .CNT_W(32)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .exmem_memop(exmem_memop),
    .branch_flush(branch_flush), .jump_flush(jump_flush), .idex_memrd(idex_memrd),
    .idex_wsel(idex_wsel), .ifid_rsel(ifid_rsel), .idex_rsel(idex_rsel),
    .exmem_regwr(exmem_regwr), .exmem_wsel(exmem_wsel),
    .memwb_regwr(memwb_regwr), .memwb_wsel(memwb_wsel),
    .pc_wen(pc_wen), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
    .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .exmem_flush(exmem_flush), .fwd_sel(fwd_sel), .wdog_err(wdog_err)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    ihit = 1'b0; dhit = 1'b0; exmem_memop = 1'b0;
    branch_flush = 1'b0; jump_flush = 1'b0; idex_memrd = 1'b0;
    idex_wsel = 5'd0; exmem_wsel = 5'd0; memwb_wsel = 5'd0;
    ifid_rsel = 10'd0; idex_rsel = 10'd0;
    exmem_regwr = 1'b0; memwb_regwr = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    nRST = 1'b0; ihit = 1'b1; dhit = 1'b1;
    exmem_regwr = 1'b1; exmem_wsel = 5'd9; idex_rsel = {5'd9, 5'd9};
    tick(); tick();
    #1;
    checks++; if (pc_wen !== 1'b0) begin errors++; $display("FAIL reset_pc_wen got=%b exp=0", pc_wen); end
    checks++; if ({ifid_en, idex_en, exmem_en, memwb_en} !== 4'b0000) begin errors++;
      $display("FAIL reset_enables got=%b exp=0000", {ifid_en, idex_en, exmem_en, memwb_en}); end
    checks++; if ({ifid_flush, idex_flush, exmem_flush} !== 3'b000) begin errors++;
      $display("FAIL reset_flushes got=%b exp=000", {ifid_flush, idex_flush, exmem_flush}); end
    checks++; if (fwd_sel !== 4'b0000) begin errors++; $display("FAIL reset_fwd_sel got=%b exp=0000", fwd_sel); end
    checks++; if (wdog_err !== 1'b0) begin errors++; $display("FAIL reset_wdog_err got=%b exp=0", wdog_err); end
    idle_inputs();
    nRST = 1'b1; ihit = 1'b1;
    #1;
    checks++; if (pc_wen !== 1'b1) begin errors++; $display("FAIL release_pc_wen got=%b exp=1", pc_wen); end
    tick();
  endtask

  task automatic test_dcache_wait();
    idle_inputs();
    exmem_memop = 1'b1; ihit = 1'b1;
    #1;
    checks++; if ({pc_wen, exmem_en, memwb_en} !== 3'b000) begin errors++;
      $display("FAIL dwait_c1 got=%b exp=000", {pc_wen, exmem_en, memwb_en}); end
    tick();
    ihit = 1'b0;
    for (int c = 2; c <= 3; c++) begin
      #1;
      checks++; if (pc_wen !== 1'b0) begin errors++; $display("FAIL dwait_c%0d_pc_wen got=%b exp=0", c, pc_wen); end
      tick();
    end
    dhit = 1'b1;
    #1;
    checks++; if ({pc_wen, idex_en, exmem_en, memwb_en, exmem_flush} !== 5'b11110) begin errors++;
      $display("FAIL dwait_release got=%b exp=11110", {pc_wen, idex_en, exmem_en, memwb_en, exmem_flush}); end
    tick();
    #1;
    checks++; if ({pc_wen, exmem_en, exmem_flush} !== 3'b011) begin errors++;
      $display("FAIL ihit_q_cleared got=%b exp=011", {pc_wen, exmem_en, exmem_flush}); end
    tick();
  endtask

  task automatic test_load_use();
    idle_inputs();
    ihit = 1'b1; idex_memrd = 1'b1; idex_wsel = 5'd8; ifid_rsel = {5'd8, 5'd3};
    #1;
    checks++; if ({pc_wen, ifid_en, idex_en, idex_flush} !== 4'b0011) begin errors++;
      $display("FAIL lu_port1 got=%b exp=0011", {pc_wen, ifid_en, idex_en, idex_flush}); end
    tick();
    ifid_rsel = {5'd3, 5'd8};
    #1;
    checks++; if ({pc_wen, idex_flush} !== 2'b01) begin errors++;
      $display("FAIL lu_port0 got=%b exp=01", {pc_wen, idex_flush}); end
    tick();
    idex_wsel = 5'd0; ifid_rsel = {5'd0, 5'd3};
    #1;
    checks++; if ({pc_wen, ifid_en, idex_flush} !== 3'b110) begin errors++;
      $display("FAIL lu_reg0 got=%b exp=110", {pc_wen, ifid_en, idex_flush}); end
    tick();
    idex_wsel = 5'd8; ifid_rsel = {5'd8, 5'd3}; idex_memrd = 1'b0;
    #1;
    checks++; if ({pc_wen, idex_flush} !== 2'b10) begin errors++;
      $display("FAIL lu_not_load got=%b exp=10", {pc_wen, idex_flush}); end
    tick();
  endtask

  task automatic test_forwarding();
    idle_inputs();
    ihit = 1'b1;
    exmem_regwr = 1'b1; exmem_wsel = 5'd9; memwb_regwr = 1'b1; memwb_wsel = 5'd9;
    idex_rsel = {5'd4, 5'd9};
    #1;
    checks++; if (fwd_sel !== 4'b0010) begin errors++; $display("FAIL fwd_exmem got=%b exp=0010", fwd_sel); end
    exmem_regwr = 1'b0;
    #1;
    checks++; if (fwd_sel !== 4'b0001) begin errors++; $display("FAIL fwd_memwb got=%b exp=0001", fwd_sel); end
    exmem_regwr = 1'b1; exmem_wsel = 5'd0; memwb_wsel = 5'd0; idex_rsel = {5'd4, 5'd0};
    #1;
    checks++; if (fwd_sel !== 4'b0000) begin errors++; $display("FAIL fwd_reg0 got=%b exp=0000", fwd_sel); end
    exmem_wsel = 5'd9; memwb_wsel = 5'd9; idex_rsel = {5'd9, 5'd9};
    #1;
    checks++; if (fwd_sel !== 4'b1010) begin errors++; $display("FAIL fwd_both_ports got=%b exp=1010", fwd_sel); end
    exmem_wsel = 5'd4; idex_rsel = {5'd4, 5'd9};
    #1;
    checks++; if (fwd_sel !== 4'b1001) begin errors++; $display("FAIL fwd_mixed got=%b exp=1001", fwd_sel); end
    tick();
  endtask

  task automatic test_branch_flush();
    idle_inputs();
    exmem_memop = 1'b1; ihit = 1'b1; branch_flush = 1'b1;
    #1;
    checks++; if ({ifid_flush, idex_flush, pc_wen} !== 3'b000) begin errors++;
      $display("FAIL br_stalled got=%b exp=000", {ifid_flush, idex_flush, pc_wen}); end
    tick();
    ihit = 1'b0; dhit = 1'b1;
    idex_memrd = 1'b1; idex_wsel = 5'd8; ifid_rsel = {5'd8, 5'd3};
    #1;
    checks++; if ({ifid_flush, idex_flush, pc_wen, ifid_en} !== 4'b1111) begin errors++;
      $display("FAIL br_go_with_lu got=%b exp=1111", {ifid_flush, idex_flush, pc_wen, ifid_en}); end
    tick();
    idle_inputs();
    ihit = 1'b1; jump_flush = 1'b1;
    #1;
    checks++; if ({ifid_flush, idex_flush, pc_wen} !== 3'b111) begin errors++;
      $display("FAIL jump_flush got=%b exp=111", {ifid_flush, idex_flush, pc_wen}); end
    tick();
  endtask

  task automatic test_watchdog();
    idle_inputs();
    exmem_memop = 1'b1;
    #1;
    checks++; if (wdog_err !== 1'b0) begin errors++; $display("FAIL wd_start got=%b exp=0", wdog_err); end
    tick();
    for (int c = 0; c < 254; c++) tick();
    checks++; if (wdog_err !== 1'b0) begin errors++; $display("FAIL wd_254 got=%b exp=0", wdog_err); end
    tick();
    checks++; if (wdog_err !== 1'b1) begin errors++; $display("FAIL wd_255 got=%b exp=1", wdog_err); end
    dhit = 1'b1; ihit = 1'b1;
    #1;
    checks++; if (pc_wen !== 1'b1) begin errors++; $display("FAIL wd_fsm_release got=%b exp=1", pc_wen); end
    tick();
    idle_inputs();
    ihit = 1'b1;
    tick(); tick();
    checks++; if (wdog_err !== 1'b1) begin errors++; $display("FAIL wd_sticky got=%b exp=1", wdog_err); end
    nRST = 1'b0;
    tick();
    nRST = 1'b1;
    #1;
    checks++; if (wdog_err !== 1'b0) begin errors++; $display("FAIL wd_cleared got=%b exp=0", wdog_err); end
    tick();
  endtask

  task automatic test_reset_mid_wait();
    idle_inputs();
    exmem_memop = 1'b1; ihit = 1'b1;
    tick();
    nRST = 1'b0; ihit = 1'b0;
    tick();
    nRST = 1'b1; exmem_memop = 1'b0;
    #1;
    checks++; if ({pc_wen, idex_en} !== 2'b00) begin errors++;
      $display("FAIL rst_mid_wait_ihit_q got=%b exp=00", {pc_wen, idex_en}); end
    tick();
  endtask

  initial begin
    idle_inputs();
    nRST = 1'b0;
    test_reset();
    test_dcache_wait();
    test_load_use();
    test_forwarding();
    test_branch_flush();
    test_watchdog();
    test_reset_mid_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
